// File: rtl/game_pkg.sv
// Shared types for the menu/game state machine and the round controller.
package game_pkg;

  typedef enum logic [2:0] {
    GS_START = 3'd0,
    GS_MENU1 = 3'd1,
    GS_MENU2 = 3'd2,
    GS_PLAY  = 3'd3,
    GS_CHECK = 3'd4,
    GS_END   = 3'd5
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_SPAWN,
    RS_COUNT,
    RS_LIVE,
    RS_HOLD,
    RS_SCORE,
    RS_REPORT,
    RS_WAIT
  } round_state_t;

  // Dead-mask bit 0 is tank 1, so a lone tank-1 death is a win for player 2.
  function automatic winner_t winner_of(input logic [1:0] mask);
    case (mask)
      2'b01:   return WIN_P2;
      2'b10:   return WIN_P1;
      2'b11:   return WIN_DRAW;
      default: return WIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Frame-tick up-counter with synchronous clear; done flags the tick that reaches limit.
module frame_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + ONE;
    end
  end

  assign done = tick && (count == (limit - ONE));

endmodule

// File: rtl/round_controller.sv
// Round sequencer: spawn, frozen countdown, live play, settle window, scoring, report.
// Optional macro DRAW_REPLAY_EN: a double death awards no point and the round is replayed.
module round_controller
  import game_pkg::*;
#(
  parameter int RESPAWN_FRAMES = 60,
  parameter int HOLD_FRAMES    = 90,
  parameter int SCORE_W        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         game_state,
  input  logic               frame_tick,
  input  logic               TankDead_1,
  input  logic               TankDead_2,
  output logic               spawn,
  output logic               freeze,
  output logic               round_active,
  output logic               round_done,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         last_winner
);

  localparam int MAX_FRAMES = (RESPAWN_FRAMES > HOLD_FRAMES) ? RESPAWN_FRAMES : HOLD_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam logic [CNT_W-1:0]   RESPAWN_LIM = CNT_W'(RESPAWN_FRAMES);
  localparam logic [CNT_W-1:0]   HOLD_LIM    = CNT_W'(HOLD_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);

  round_state_t     state, state_next;
  logic [1:0]       deaths, dead_mask, final_mask;
  logic             abort, in_play, prev_play;
  logic             counting, cnt_tick, cnt_done;
  logic [CNT_W-1:0] cnt_limit;

  assign deaths     = {TankDead_2, TankDead_1};
  assign final_mask = dead_mask | deaths;
  assign abort      = (game_state == GS_START);
  assign in_play    = (game_state == GS_PLAY);

  // One counter serves both the countdown and the settle window; it idles cleared elsewhere.
  assign counting  = (state == RS_COUNT) || (state == RS_HOLD);
  assign cnt_tick  = frame_tick && counting;
  assign cnt_limit = (state == RS_HOLD) ? HOLD_LIM : RESPAWN_LIM;

  frame_counter #(.W(CNT_W)) u_frame_counter (
    .clk   (clk),
    .reset (reset),
    .clear (!counting),
    .tick  (cnt_tick),
    .limit (cnt_limit),
    .done  (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RS_IDLE;
      prev_play <= 1'b0;
      dead_mask <= 2'b00;
    end else begin
      state     <= state_next;
      prev_play <= in_play;
      if (state == RS_LIVE) begin
        dead_mask <= deaths;
      end else if (state == RS_HOLD) begin
        dead_mask <= final_mask;
      end
    end
  end

  always_comb begin
    state_next   = state;
    spawn        = 1'b0;
    freeze       = 1'b1;
    round_active = 1'b0;
    round_done   = 1'b0;
    case (state)
      RS_IDLE:   if (in_play) state_next = RS_SPAWN;
      RS_SPAWN: begin
        spawn      = 1'b1;
        state_next = RS_COUNT;
      end
      RS_COUNT:  if (cnt_done) state_next = RS_LIVE;
      RS_LIVE: begin
        freeze       = 1'b0;
        round_active = 1'b1;
        if (|deaths) state_next = RS_HOLD;
      end
      RS_HOLD: begin
        freeze = 1'b0;
        if (cnt_done) state_next = RS_SCORE;
      end
      RS_SCORE:  state_next = RS_REPORT;
      RS_REPORT: begin
        round_done = 1'b1;
        state_next = RS_WAIT;
      end
      // A new round needs a fresh entry into play, so a lingering play state cannot respawn.
      RS_WAIT: begin
        if (in_play && !prev_play) begin
          state_next = RS_SPAWN;
        end else if (game_state == GS_END) begin
          state_next = RS_IDLE;
        end
      end
      default:   state_next = RS_IDLE;
    endcase
    if (abort) state_next = RS_IDLE;
  end

  // Scores land on the edge into SCORE so they are stable a cycle before round_done.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      p1_score    <= '0;
      p2_score    <= '0;
      last_winner <= WIN_NONE;
    end else if (state == RS_HOLD && cnt_done) begin
      case (final_mask)
        2'b01: if (p2_score != SCORE_MAX) p2_score <= p2_score + SCORE_ONE;
        2'b10: if (p1_score != SCORE_MAX) p1_score <= p1_score + SCORE_ONE;
        2'b11: begin
`ifdef DRAW_REPLAY_EN
          p1_score <= p1_score;
          p2_score <= p2_score;
`else
          if (p1_score != SCORE_MAX) p1_score <= p1_score + SCORE_ONE;
          if (p2_score != SCORE_MAX) p2_score <= p2_score + SCORE_ONE;
`endif
        end
        default: ;
      endcase
      last_winner <= winner_of(final_mask);
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Randomised round-level bench for round_controller; scores predicted from round outcomes.
module tb_round_controller;

  localparam int RESPAWN = 60;
  localparam int HOLD    = 90;
  localparam int SW      = 4;
  localparam int SMAX    = (1 << SW) - 1;

  localparam int CLEAN = 0;
  localparam int LATE2 = 1;
  localparam int NOISY = 2;
  localparam int HELD  = 3;
  localparam int ABORT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    game_state;
  logic          frame_tick;
  logic          TankDead_1;
  logic          TankDead_2;
  logic          spawn;
  logic          freeze;
  logic          round_active;
  logic          round_done;
  logic [SW-1:0] p1_score;
  logic [SW-1:0] p2_score;
  logic [1:0]    last_winner;

  int         vectors     = 0;
  int         miscompares = 0;
  int         expP1       = 0;
  int         expP2       = 0;
  logic [1:0] expWin      = 2'b00;
  bit         fromWait    = 1'b0;
  logic [2:0] gsTable [4] = '{3'd1, 3'd2, 3'd4, 3'd5};

  round_controller #(
    .RESPAWN_FRAMES (RESPAWN),
    .HOLD_FRAMES    (HOLD),
    .SCORE_W        (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .game_state   (game_state),
    .frame_tick   (frame_tick),
    .TankDead_1   (TankDead_1),
    .TankDead_2   (TankDead_2),
    .spawn        (spawn),
    .freeze       (freeze),
    .round_active (round_active),
    .round_done   (round_done),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .last_winner  (last_winner)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no end of run, expected $finish before 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs held for one clock; outputs are then looked at on the following falling edge.
  task automatic applyStimulus(input logic [2:0] gs, input logic ft, input logic d1, input logic d2);
    game_state = gs;
    frame_tick = ft;
    TankDead_1 = d1;
    TankDead_2 = d2;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [1:0] noiseFor(input int mode);
    if (mode == NOISY) return 2'($urandom_range(0, 3));
    return 2'b00;
  endfunction

  function automatic logic randBit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Bit 0 of a mask is tank 1: a tank-1 death is a point for player 2.
  function automatic void awardRound(input logic [1:0] mask);
    case (mask)
      2'b01: begin
        expP2  = (expP2 < SMAX) ? expP2 + 1 : SMAX;
        expWin = 2'b10;
      end
      2'b10: begin
        expP1  = (expP1 < SMAX) ? expP1 + 1 : SMAX;
        expWin = 2'b01;
      end
      2'b11: begin
`ifndef DRAW_REPLAY_EN
        expP1 = (expP1 < SMAX) ? expP1 + 1 : SMAX;
        expP2 = (expP2 < SMAX) ? expP2 + 1 : SMAX;
`endif
        expWin = 2'b11;
      end
      default: expWin = 2'b00;
    endcase
  endfunction

  task automatic playRound(input logic [1:0] firstMask, input int mode);
    int         ticks;
    int         holdTicks;
    int         abortAt;
    logic       h2;
    logic       ft;
    logic [1:0] d;
    logic [1:0] mask;
    h2 = (mode == HELD);

    if (fromWait) begin
      for (int i = 0; i < 2; i++) begin
        applyStimulus(3'd3, 1'b0, 1'b0, h2);
        checkOutput("wait_no_respawn", 16'(spawn), 16'd0);
      end
    end
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
      d = noiseFor(mode);
      applyStimulus(gsTable[$urandom_range(0, 3)], randBit(), d[0], d[1] | h2);
      checkOutput("gap_no_spawn", 16'(spawn), 16'd0);
    end

    applyStimulus(3'd3, 1'b0, 1'b0, h2);
    checkOutput("spawn_pulse", {14'd0, spawn, freeze}, 16'b11);
    applyStimulus(3'd3, randBit(), 1'b0, h2);
    checkOutput("spawn_single", {12'd0, spawn, freeze, round_active, round_done}, 16'b0100);

    // Countdown: only ticks seen after the spawn cycle count.
    ticks = 0;
    while (ticks < RESPAWN) begin
      d  = noiseFor(mode);
      ft = 1'($urandom_range(0, 2) != 0);
      applyStimulus(3'd3, ft, d[0], d[1] | h2);
      if (ft) ticks++;
      if (ticks < RESPAWN)
        checkOutput("count_frozen", {12'd0, spawn, freeze, round_active, round_done}, 16'b0100);
      else
        checkOutput("live_rise", {12'd0, spawn, freeze, round_active, round_done}, 16'b0010);
    end

    for (int i = 0; i < (h2 ? 0 : int'($urandom_range(0, 3))); i++) begin
      applyStimulus(3'd3, randBit(), 1'b0, 1'b0);
      checkOutput("live_stays", {12'd0, spawn, freeze, round_active, round_done}, 16'b0010);
    end

    // First death, possibly alongside a frame tick that must not count.
    applyStimulus(3'd3, randBit(), firstMask[0], firstMask[1]);
    mask = firstMask;
    checkOutput("hold_entry", {13'd0, spawn, freeze, round_done}, 16'b000);

    holdTicks = 0;
    abortAt   = (mode == ABORT) ? int'($urandom_range(5, 85)) : -1;
    while (holdTicks < HOLD) begin
      if (holdTicks == abortAt) begin
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_idle", {12'd0, spawn, freeze, round_active, round_done}, 16'b0100);
        checkOutput("abort_p1", 16'(p1_score), 16'd0);
        checkOutput("abort_p2", 16'(p2_score), 16'd0);
        checkOutput("abort_winner", 16'(last_winner), 16'd0);
        expP1  = 0;
        expP2  = 0;
        expWin = 2'b00;
        for (int i = 0; i < 5; i++) begin
          applyStimulus(3'd0, randBit(), randBit(), randBit());
          checkOutput("abort_no_done", 16'(round_done), 16'd0);
        end
        fromWait = 1'b0;
        return;
      end
      case (mode)
        LATE2:   d = (holdTicks == 40) ? 2'b10 : 2'b00;
        NOISY:   d = {firstMask[1] ? randBit() : 1'($urandom_range(0, 49) == 0),
                      firstMask[0] ? randBit() : 1'($urandom_range(0, 49) == 0)};
        HELD:    d = 2'b10;
        default: d = 2'b00;
      endcase
      ft = randBit();
      applyStimulus(3'd3, ft, d[0], d[1]);
      mask = mask | d;
      if (ft) holdTicks++;
      if (holdTicks < HOLD)
        checkOutput("hold_no_done", {14'd0, freeze, round_done}, 16'b00);
    end

    awardRound(mask);
    checkOutput("score_p1", 16'(p1_score), 16'(expP1));
    checkOutput("score_p2", 16'(p2_score), 16'(expP2));
    checkOutput("score_winner", 16'(last_winner), 16'(expWin));
    checkOutput("score_before_done", 16'(round_done), 16'd0);

    d = noiseFor(mode);
    applyStimulus(3'd3, randBit(), d[0], d[1] | h2);
    checkOutput("report_done", {14'd0, round_done, freeze}, 16'b11);
    checkOutput("report_p1", 16'(p1_score), 16'(expP1));
    checkOutput("report_p2", 16'(p2_score), 16'(expP2));

    applyStimulus(3'd3, 1'b0, 1'b0, h2);
    checkOutput("wait_done_low", {13'd0, round_done, freeze, spawn}, 16'b010);
    fromWait = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_ctrl", {12'd0, spawn, freeze, round_active, round_done}, 16'b0100);
    checkOutput("reset_p1", 16'(p1_score), 16'd0);
    checkOutput("reset_p2", 16'(p2_score), 16'd0);
    checkOutput("reset_winner", 16'(last_winner), 16'd0);
    reset = 1'b0;
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_ctrl", {12'd0, spawn, freeze, round_active, round_done}, 16'b0100);

    playRound(2'b01, CLEAN);
    playRound(2'b01, LATE2);
    playRound(2'b10, HELD);
    playRound(2'b10, HELD);
    for (int i = 0; i < 4; i++) playRound(2'($urandom_range(1, 3)), NOISY);
    for (int i = 0; i < 16; i++) playRound(2'b10, CLEAN);
    playRound(2'b01, ABORT);
    playRound(2'b10, CLEAN);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
